// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM states, byte-enable constants,
// default timeout sizing and the alignment rule.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int         DEF_TIMEOUT_CYCLES = 64;
    localparam int         DEF_CNT_W          = 7;
    localparam logic [3:0] BE_NONE            = 4'h0;
    localparam logic [3:0] BE_WORD            = 4'hF;

    // Byte accesses are always aligned; words need addr[1:0]==0.
    function automatic logic is_misaligned(input logic is_byte, input logic [1:0] addr_lo);
        return !is_byte && (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store data replication / byte enables and
// load lane selection with sign extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic        i_is_byte,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_load_data
);

    logic [7:0] w_lane [4];
    logic [3:0] w_byte_be;
    logic [7:0] w_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi]    = i_rdata[8*gi +: 8];
            assign w_byte_be[gi] = (i_addr_lo == 2'(gi));
        end
    endgenerate

    assign w_sel       = w_lane[i_addr_lo];
    assign o_wdata     = i_is_byte ? {4{i_store_data[7:0]}} : i_store_data;
    assign o_be        = i_is_byte ? w_byte_be : BE_WORD;
    assign o_load_data = i_is_byte ? {{24{w_sel[7]}}, w_sel} : i_rdata;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: word/byte loads and stores over a req/ack port,
// branch resolution, and one registered writeback result per instruction.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        zero_in,
    input  logic [31:0] branch_tgt,
    input  logic [4:0]  dest_reg,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    input  logic        branch,
    input  logic        reg_write,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        mem_fault
);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr, r_store_data, r_result;
    logic [4:0]       r_dest;
    logic             r_is_load, r_is_byte, r_reg_write, r_fault_op;
    logic             r_wb_valid, r_wb_en, r_pc_src, r_mem_fault;
    logic [31:0]      r_wb_data, r_pc_target;
    logic [4:0]       r_wb_reg;

    logic        w_is_mem, w_accept, w_misaligned, w_timeout;
    logic [31:0] w_wdata, w_load_data;
    logic [3:0]  w_be;

    assign w_is_mem     = mem_read | mem_write;
    assign w_accept     = (r_state == ST_IDLE) && valid_in;
    assign w_misaligned = is_misaligned(mem_byte, alu_result[1:0]);
    assign w_timeout    = (r_state == ST_REQ) && !dmem_ack
                          && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    mem_align u_align (
        .i_is_byte    (r_is_byte),
        .i_addr_lo    (r_addr[1:0]),
        .i_store_data (r_store_data),
        .i_rdata      (dmem_rdata),
        .o_wdata      (w_wdata),
        .o_be         (w_be),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        dmem_be      = BE_NONE;
        unique case (r_state)
            ST_IDLE: begin
                // Stall is raised in the accept cycle itself, before any state change.
                if (w_accept && w_is_mem && !reset) stall = 1'b1;
                if (w_accept && w_is_mem && !w_misaligned) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                stall      = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = !r_is_load;
                dmem_addr  = r_is_byte ? r_addr : {r_addr[31:2], 2'b00};
                dmem_wdata = r_is_load ? 32'h0 : w_wdata;
                dmem_be    = w_be;
                if (dmem_ack || w_timeout) w_state_next = ST_RESP;
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_addr       <= '0;
            r_store_data <= '0;
            r_result     <= '0;
            r_dest       <= '0;
            r_is_load    <= 1'b0;
            r_is_byte    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_fault_op   <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_en      <= 1'b0;
            r_wb_data    <= '0;
            r_wb_reg     <= '0;
            r_pc_src     <= 1'b0;
            r_pc_target  <= '0;
            r_mem_fault  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_pc_src   <= 1'b0;
            r_cnt      <= (r_state == ST_REQ) ? r_cnt + CNT_W'(1) : '0;

            if (w_accept) begin
                r_addr       <= alu_result;
                r_store_data <= store_data;
                r_result     <= alu_result;
                r_dest       <= dest_reg;
                r_is_load    <= mem_read;
                r_is_byte    <= mem_byte;
                r_reg_write  <= reg_write;
                r_fault_op   <= 1'b0;
                if (!w_is_mem) begin
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= alu_result;
                    r_wb_reg   <= dest_reg;
                    r_wb_en    <= reg_write & !branch;
                    if (branch && zero_in) begin
                        r_pc_src    <= 1'b1;
                        r_pc_target <= branch_tgt;
                    end
                end else if (w_misaligned) begin
                    r_wb_valid  <= 1'b1;
                    r_wb_data   <= alu_result;
                    r_wb_reg    <= dest_reg;
                    r_wb_en     <= 1'b0;
                    r_mem_fault <= 1'b1;
                end
            end

            if (r_state == ST_REQ) begin
                if (dmem_ack) begin
                    if (r_is_load) r_result <= w_load_data;
                end else if (w_timeout) begin
                    r_fault_op  <= 1'b1;
                    r_mem_fault <= 1'b1;
                end
            end

            // The writeback register is loaded while in RESP, so the result appears as RESP exits.
            if (r_state == ST_RESP) begin
                r_wb_valid <= 1'b1;
                r_wb_data  <= r_result;
                r_wb_reg   <= r_dest;
                r_wb_en    <= r_is_load & r_reg_write & !r_fault_op;
            end
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_en     = r_wb_en;
    assign wb_data   = r_wb_data;
    assign wb_reg    = r_wb_reg;
    assign pc_src    = r_pc_src;
    assign pc_target = r_pc_target;
    assign mem_fault = r_mem_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: the driver acts as upstream and
// data memory, and a monitor compares every writeback against queued expectations.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result, store_data, branch_tgt;
    logic        zero_in;
    logic [4:0]  dest_reg;
    logic        mem_read, mem_write, mem_byte, branch, reg_write;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_en;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        mem_fault;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .alu_result (alu_result),
        .store_data (store_data),
        .zero_in    (zero_in),
        .branch_tgt (branch_tgt),
        .dest_reg   (dest_reg),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_byte   (mem_byte),
        .branch     (branch),
        .reg_write  (reg_write),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_en      (wb_en),
        .wb_data    (wb_data),
        .wb_reg     (wb_reg),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .mem_fault  (mem_fault)
    );

    typedef struct packed {
        logic        en;
        logic [31:0] data;
        logic [4:0]  rg;
        logic        pc;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    logic exp_fault = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_en", {31'd0, wb_en}, {31'd0, mon_e.en});
                check("wb_data", wb_data, mon_e.data);
                check("wb_reg", {27'd0, wb_reg}, {27'd0, mon_e.rg});
                check("pc_src", {31'd0, pc_src}, {31'd0, mon_e.pc});
                if (mon_e.pc) check("pc_target", pc_target, mon_e.tgt);
                $display("wb reg=%0d data=%h en=%0b pc_src=%0b", wb_reg, wb_data, wb_en, pc_src);
            end
        end else if (pc_src !== 1'b0) begin
            check("pc_src_stray", {31'd0, pc_src}, 32'd0);
        end
    end

    task automatic idle_inputs();
        valid_in   = 1'b0;
        alu_result = '0;
        store_data = '0;
        branch_tgt = '0;
        zero_in    = 1'b0;
        dest_reg   = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_byte   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] a, input logic [4:0] d, input logic rw,
                          input logic br, input logic z, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        alu_result = a;   dest_reg = d;  reg_write = rw;
        branch     = br;  zero_in  = z;  branch_tgt = tgt;
        mem_read   = 1'b0; mem_write = 1'b0; mem_byte = 1'b0;
        valid_in   = 1'b1;
        e.en   = rw & ~br;
        e.data = a;
        e.rg   = d;
        e.pc   = br & z;
        e.tgt  = tgt;
        sb.push_back(e);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // delay < 0 means memory never acknowledges.
    task automatic mem_op(input logic rd, input logic wr, input logic by,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d,
                          input logic rw, input int delay, input logic [31:0] rdat);
        exp_t        e;
        logic [1:0]  lane;
        logic [7:0]  b;
        logic        mis;
        int          k;
        int          exp_cycles;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        lane = a[1:0];
        mis  = !by && (lane != 2'b00);
        @(negedge clk);
        alu_result = a;  store_data = sd; dest_reg = d; reg_write = rw;
        mem_read   = rd; mem_write  = wr; mem_byte = by;
        branch     = 1'b0; zero_in = $urandom_range(0, 1);
        valid_in   = 1'b1;
        e.rg = d; e.pc = 1'b0; e.tgt = '0; e.data = a; e.en = 1'b0;
        if (mis) begin
            sb.push_back(e);
            #1 check("stall_on_accept", {31'd0, stall}, 32'd1);
            @(negedge clk);
            valid_in  = 1'b0;
            exp_fault = 1'b1;
            check("mis_no_req", {31'd0, dmem_req}, 32'd0);
            check("mis_fault", {31'd0, mem_fault}, 32'd1);
            return;
        end
        if (rd && delay >= 0) begin
            b      = rdat[8*lane +: 8];
            e.data = by ? {{24{b[7]}}, b} : rdat;
            e.en   = rw;
        end
        sb.push_back(e);
        exp_addr   = by ? a : {a[31:2], 2'b00};
        exp_be     = by ? (4'b0001 << lane) : 4'hF;
        exp_wdata  = by ? {4{sd[7:0]}} : sd;
        exp_cycles = (delay >= 0) ? delay + 1 : 64;
        #1 check("stall_on_accept", {31'd0, stall}, 32'd1);
        @(negedge clk);
        k = 0;
        while (dmem_req === 1'b1 && k < 200) begin
            if (k == 0) begin
                check("dmem_addr", dmem_addr, exp_addr);
                check("dmem_we", {31'd0, dmem_we}, {31'd0, ~rd});
                check("stall_in_req", {31'd0, stall}, 32'd1);
                if (!rd) begin
                    check("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be});
                    check("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end
            if (k == delay) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdat;
            end
            k++;
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
        end
        check("req_cycles", k, exp_cycles);
        check("stall_in_resp", {31'd0, stall}, 32'd0);
        valid_in = 1'b0;
        if (delay < 0) exp_fault = 1'b1;
        check("mem_fault", {31'd0, mem_fault}, {31'd0, exp_fault});
        $display("mem rd=%0b wr=%0b byte=%0b addr=%h req_cycles=%0d", rd, wr, by, a, k);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          op;
        logic        by;
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_mem_fault", {31'd0, mem_fault}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_pc_src", {31'd0, pc_src}, 32'd0);
        reset = 1'b0;

        alu_op(32'h22, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
        alu_op(32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 32'h40);
        alu_op(32'h5, 5'd8, 1'b1, 1'b1, 1'b0, 32'h80);
        mem_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 5'd3, 1'b1, 2, 32'hDEADBEEF);
        mem_op(1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 5'd4, 1'b1, 0, 32'h80112233);
        mem_op(1'b0, 1'b1, 1'b1, 32'h11, 32'hAB, 5'd6, 1'b1, 1, 32'h0);
        mem_op(1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 5'd9, 1'b0, 3, 32'h0);

        @(negedge clk);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("idle_ack_no_req", {31'd0, dmem_req}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            by = $urandom_range(0, 1);
            a  = $urandom;
            if (!by) a[1:0] = 2'b00;
            case (op)
                0: alu_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
                1: mem_op(1'b1, 1'b0, by, a, $urandom, 5'($urandom), 1'($urandom),
                          $urandom_range(0, 5), $urandom);
                2: mem_op(1'b0, 1'b1, by, a, $urandom, 5'($urandom), 1'($urandom),
                          $urandom_range(0, 5), $urandom);
                default: mem_op(1'b1, 1'b1, by, a, $urandom, 5'($urandom), 1'($urandom),
                                $urandom_range(0, 5), $urandom);
            endcase
        end

        mem_op(1'b0, 1'b1, 1'b0, 32'h6, 32'h55, 5'd10, 1'b1, 0, 32'h0);
        mem_op(1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 5'd11, 1'b1, -1, 32'h0);

        @(negedge clk);
        alu_result = 32'h44; mem_read = 1'b1; mem_write = 1'b0; mem_byte = 1'b0;
        dest_reg = 5'd12; reg_write = 1'b1; valid_in = 1'b1;
        @(negedge clk);
        check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_req", {31'd0, dmem_req}, 32'd0);
        check("async_rst_stall", {31'd0, stall}, 32'd0);
        check("async_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("async_rst_fault", {31'd0, mem_fault}, 32'd0);
        valid_in  = 1'b0;
        exp_fault = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;

        mem_op(1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 5'd13, 1'b1, 1, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
